thermo_pp_accumulator: RTL

Sequential accumulator directly downstream of `binary_to_thermometer` in the parallel thermometer partial-product adder. It accepts a stream of signed, thermometer-coded partial products over a valid/ready handshake. It reduces each code to its magnitude and sums a frame of `NUM_TERMS` terms in two's complement. The frame sum is then presented on an output handshake to the next adder stage.

---
 rtl/thermo_pp_accumulator_if.sv | 29 ++
 rtl/thermo_pp_accumulator.sv | 101 ++++++++++
 2 files changed

// File: rtl/thermo_pp_accumulator_if.sv
// Handshake bundle between the thermometer converter, the accumulator
// and the next adder stage.
interface thermo_pp_accumulator_if #(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_TERMS   = 8
);
  localparam int THERM_W   = 2**INPUT_WIDTH - 1;
  localparam int ACC_WIDTH = $clog2(NUM_TERMS*THERM_W + 1) + 1;

  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [THERM_W-1:0]          therm_in;
  logic                        sign_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] sum_out;
  logic                        code_err;

  modport master (
    output flush, in_valid, therm_in, sign_in, out_ready,
    input  in_ready, out_valid, sum_out, code_err
  );

  modport slave (
    input  flush, in_valid, therm_in, sign_in, out_ready,
    output in_ready, out_valid, sum_out, code_err
  );
endinterface

// File: rtl/thermo_pp_accumulator.sv
// Sums frames of NUM_TERMS signed thermometer-coded terms and hands the
// two's-complement frame sum downstream over a valid/ready handshake.
module thermo_pp_accumulator #(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_TERMS   = 8
) (
  input logic                    clk,
  input logic                    rst,
  thermo_pp_accumulator_if.slave bus
);
  localparam int THERM_W   = 2**INPUT_WIDTH - 1;
  localparam int ACC_WIDTH = $clog2(NUM_TERMS*THERM_W + 1) + 1;
  localparam int CNT_W     = $clog2(NUM_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        cerr_q, cerr_d;

  logic [ACC_WIDTH-1:0]        mag;
  logic signed [ACC_WIDTH-1:0] term;
  logic [THERM_W-1:0]          plus1;
  logic                        illegal;

  // Bubbled codes still count their ones; only the flag records them.
  always_comb begin
    mag = '0;
    for (int i = 0; i < THERM_W; i++) begin
      mag = mag + ACC_WIDTH'(bus.therm_in[i]);
    end
    term    = bus.sign_in ? -$signed(mag) : $signed(mag);
    plus1   = bus.therm_in + THERM_W'(1);
    illegal = |(bus.therm_in & plus1);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    cerr_d  = cerr_q;
    if (bus.flush) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            if (cnt_q == LAST) begin
              sum_d   = acc_q + term;
              cerr_d  = err_q | illegal;
              acc_d   = '0;
              cnt_d   = '0;
              err_d   = 1'b0;
              state_d = DONE;
            end else begin
              acc_d = acc_q + term;
              cnt_d = cnt_q + CNT_W'(1);
              err_d = err_q | illegal;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      cerr_q  <= cerr_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.code_err  = cerr_q;
endmodule
